// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter with a first-word-fall-through input FIFO,
//               selectable parity (none/even/odd) and 1 or 2 stop bits.
//               Frames are sent LSB-first, one bit per i_uart_en strobe, and
//               run back-to-back while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int N_DATA_BITS = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                             i_uart_clk,
    input  logic                             i_uart_reset,
    input  logic                             i_uart_en,
    input  logic                             i_uart_data_valid,
    input  logic [N_DATA_BITS-1:0]           i_uart_data,
    input  logic [1:0]                       i_uart_parity_mode,
    input  logic                             i_uart_two_stop,
    output logic                             o_uart_ready,
    output logic                             o_uart_tx,
    output logic                             o_uart_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_uart_fifo_count
);

    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);
    localparam int c_bw = $clog2(N_DATA_BITS + 1);

    localparam logic [c_cw-1:0] c_full     = c_cw'(FIFO_DEPTH);
    localparam logic [c_bw-1:0] c_last_bit = c_bw'(N_DATA_BITS);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // FIFO storage and bookkeeping
    logic [N_DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]        r_wr_ptr;
    logic [c_aw-1:0]        r_rd_ptr;
    logic [c_cw-1:0]        r_count;

    // Transmitter state
    logic [2:0]             r_state;
    logic [N_DATA_BITS-1:0] r_shift;
    logic [c_bw-1:0]        r_bit_cnt;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_two_stop;
    logic                   r_stop_cnt;
    logic                   r_tx;
    logic                   r_busy;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_not_empty;
    logic                   w_frame_end;
    logic [N_DATA_BITS-1:0] w_rd_data;
    logic                   w_load_par_en;
    logic                   w_load_par_bit;

    // A full FIFO refuses pushes even if a pop frees a slot in the same cycle
    assign w_push      = i_uart_data_valid && (r_count != c_full);
    assign w_not_empty = (r_count != '0);
    assign w_rd_data   = r_mem[r_rd_ptr];

    // Last stop bit is being completed on this tick
    assign w_frame_end = (r_state == c_st_stop) && (!r_two_stop || r_stop_cnt);

    // Words leave the FIFO only at a frame start: from idle or straight out of the stop bit
    assign w_pop = i_uart_en && w_not_empty &&
                   ((r_state == c_st_idle) || w_frame_end);

    // Parity configuration is sampled together with the word it applies to
    assign w_load_par_en  = (i_uart_parity_mode == 2'b01) || (i_uart_parity_mode == 2'b10);
    assign w_load_par_bit = (^w_rd_data) ^ (i_uart_parity_mode == 2'b10);

    // FIFO storage write; contents need no reset because the pointers gate validity
    always_ff @(posedge i_uart_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_uart_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer: all state and line changes happen on baud ticks only
    always_ff @(posedge i_uart_clk) begin
        if (i_uart_reset) begin
            r_state    <= c_st_idle;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else if (w_pop) begin
            // New frame: latch word and its configuration, drive the start bit
            r_shift    <= w_rd_data;
            r_par_en   <= w_load_par_en;
            r_par_bit  <= w_load_par_bit;
            r_two_stop <= i_uart_two_stop;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= c_st_start;
        end else if (i_uart_en) begin
            case (r_state)
                c_st_idle: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                c_st_start: begin
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= c_bw'(1);
                    r_state   <= c_st_data;
                end
                c_st_data: begin
                    if (r_bit_cnt == c_last_bit) begin
                        if (r_par_en) begin
                            r_tx    <= r_par_bit;
                            r_state <= c_st_parity;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= c_st_stop;
                        end
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + c_bw'(1);
                    end
                end
                c_st_parity: begin
                    r_tx       <= 1'b1;
                    r_stop_cnt <= 1'b0;
                    r_state    <= c_st_stop;
                end
                c_st_stop: begin
                    if (!w_frame_end) begin
                        r_stop_cnt <= 1'b1;
                    end else begin
                        // Queue drained: line stays high and the frame closes
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_uart_ready      = (r_count != c_full);
    assign o_uart_tx         = r_tx;
    assign o_uart_busy       = r_busy;
    assign o_uart_fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo (N=8, depth 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic [1:0] mode;
    logic       two_stop;
    logic       ready;
    logic       tx;
    logic       busy;
    logic [4:0] count;

    int total;
    int bad;

    uart_tx_fifo #(
        .N_DATA_BITS (8),
        .FIFO_DEPTH  (16)
    ) dut (
        .i_uart_clk         (clk),
        .i_uart_reset       (rst),
        .i_uart_en          (en),
        .i_uart_data_valid  (valid),
        .i_uart_data        (data),
        .i_uart_parity_mode (mode),
        .i_uart_two_stop    (two_stop),
        .o_uart_ready       (ready),
        .o_uart_tx          (tx),
        .o_uart_busy        (busy),
        .o_uart_fifo_count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the directed sequence never completes
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue one word with the baud tick held off
    task automatic push(input logic [7:0] d);
        en    = 1'b0;
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // One baud strobe every 'period' cycles; bits[i] is the expected line after tick i
    task automatic expect_frame(input string tag, input logic [15:0] bits, input int len,
                                input int period, input int cnt0);
        for (int i = 0; i < len; i++) begin
            en = 1'b0;
            repeat (period - 1) @(negedge clk);
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            chk({tag, "_tx"}, tx, bits[i]);
            chk({tag, "_busy"}, busy, 1'b1);
            if (i == 0 && cnt0 >= 0) chk({tag, "_cnt"}, count, cnt0);
        end
    endtask

    // One tick with nothing queued: line high, not busy
    task automatic idle_tick(input string tag, input int period);
        en = 1'b0;
        repeat (period - 1) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk({tag, "_idle_tx"}, tx, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        en       = 1'b0;
        valid    = 1'b0;
        data     = 8'h00;
        mode     = 2'b00;
        two_stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cnt", count, 5'd0);
        chk("rst_ready", ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Plain 8N1 frame of 0xA5
        push(8'hA5);
        chk("a5_cnt_push", count, 5'd1);
        chk("a5_busy_pre", busy, 1'b0);
        expect_frame("a5_8n1", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1, 0);
        idle_tick("a5_8n1", 1);

        // Even parity: 0xA5 has four ones -> parity 0
        mode = 2'b01;
        push(8'hA5);
        expect_frame("a5_even", {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 1, 0);
        idle_tick("a5_even", 1);

        // Odd parity -> parity 1
        mode = 2'b10;
        push(8'hA5);
        expect_frame("a5_odd", {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1, 0);
        idle_tick("a5_odd", 1);

        // Mode 11 behaves as no parity
        mode = 2'b11;
        push(8'hA5);
        expect_frame("a5_m11", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1, 0);
        idle_tick("a5_m11", 1);

        // Even parity with two stop bits: 12 ticks
        mode     = 2'b01;
        two_stop = 1'b1;
        push(8'hA5);
        expect_frame("a5_e2", {4'b0, 2'b11, 1'b0, 8'hA5, 1'b0}, 12, 1, 0);
        idle_tick("a5_e2", 1);

        // Three queued words, tick every 4th cycle, contiguous frames
        mode     = 2'b00;
        two_stop = 1'b0;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        chk("b2b_cnt", count, 5'd3);
        expect_frame("b2b_00", {6'b0, 1'b1, 8'h00, 1'b0}, 10, 4, 2);
        expect_frame("b2b_ff", {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4, 1);
        expect_frame("b2b_3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, 0);
        idle_tick("b2b", 4);

        // Fill to capacity with valid held; the 17th word is refused
        en    = 1'b0;
        valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            data = 8'h40 + 8'(i);
            chk("full_ready", ready, (i < 16) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        valid = 1'b0;
        chk("full_cnt", count, 5'd16);
        chk("full_ready_end", ready, 1'b0);
        for (int k = 0; k < 16; k++) begin
            w = 8'h40 + 8'(k);
            expect_frame("full_tx", {6'b0, 1'b1, w, 1'b0}, 10, 1, (k == 0) ? 15 : -1);
            if (k == 0) chk("full_ready_pop", ready, 1'b1);
        end
        chk("full_cnt_drained", count, 5'd0);
        idle_tick("full", 1);

        // Reset during the 4th data bit with two words still queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        expect_frame("rstmid", {11'b0, 1'b0, 4'b0001, 1'b0}, 5, 1, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_tx", tx, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_cnt", count, 5'd0);
        chk("rstmid_ready", ready, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle_tick("rstmid_after", 1);
        end

        // Config changed after the start tick applies only to the next frame
        mode     = 2'b00;
        two_stop = 1'b0;
        push(8'hA5);
        push(8'h5A);
        expect_frame("cfg1_start", 16'h0000, 1, 1, 1);
        mode     = 2'b01;
        two_stop = 1'b1;
        expect_frame("cfg1_rest", {7'b0, 1'b1, 8'hA5}, 9, 1, -1);
        expect_frame("cfg2", {4'b0, 2'b11, 1'b0, 8'h5A, 1'b0}, 12, 1, 0);
        idle_tick("cfg", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
